// File: rtl/sync_fifo_pkg.sv
// Width helpers shared by the sync_fifo block. Every width in the block is
// derived from the FIFO depth through these functions.
package sync_fifo_pkg;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so that occupancy can represent a completely full FIFO.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo: one write port and one registered read port.
// Only the read data register is reset; the array itself is left without reset.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              wr_en_i,
   input  logic [addr_w(DATA_DEPTH)-1:0]     wr_addr_i,
   input  logic [DATA_WIDTH-1:0]             wr_data_i,
   input  logic                              rd_en_i,
   input  logic [addr_w(DATA_DEPTH)-1:0]     rd_addr_i,
   output logic [DATA_WIDTH-1:0]             rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read data holds its last value when no read is accepted.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         rd_data_d = mem_q[rd_addr_i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, read-valid strobe, count and flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add wr_overflow_o / rd_underflow_o pulse outputs.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           wr_en_i,
   input  logic [DATA_WIDTH-1:0]          wr_data_i,
   input  logic                           rd_en_i,
   output logic                           rd_data_valid_o,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic [cnt_w(DATA_DEPTH)-1:0]   elem_cnt_o,
   output logic                           full_o,
   output logic                           empty_o
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic                           wr_overflow_o,
   output logic                           rd_underflow_o
`endif
);

   localparam int ADDR_W = addr_w(DATA_DEPTH);
   localparam int CNT_W  = cnt_w(DATA_DEPTH);

   logic [CNT_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q, cnt_d, cnt_q;
   logic             full_d, full_q, empty_d, empty_q, rd_valid_q;
   logic             rd_acc, wr_acc;

   always_comb begin
      rd_acc   = rd_en_i & ~empty_q;
      // A full FIFO still takes a write when a read frees a slot in the same cycle.
      wr_acc   = wr_en_i & (~full_q | rd_acc);
      wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
      rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
      // Wrap-bit pointers make the modular difference the exact occupancy 0..DEPTH.
      cnt_d    = wr_ptr_d - rd_ptr_d;
      full_d   = (cnt_d == CNT_W'(DATA_DEPTH));
      empty_d  = (cnt_d == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_valid_q <= rd_acc;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH)
   ) u_mem (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
      .rd_data_o (rd_data_o)
   );

   assign rd_data_valid_o = rd_valid_q;
   assign elem_cnt_o      = cnt_q;
   assign full_o          = full_q;
   assign empty_o         = empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic wr_ovf_d, wr_ovf_q, rd_udf_d, rd_udf_q;

   always_comb begin
      wr_ovf_d = wr_en_i & ~wr_acc;
      rd_udf_d = rd_en_i & empty_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ovf_q <= 1'b0;
         rd_udf_q <= 1'b0;
      end else begin
         wr_ovf_q <= wr_ovf_d;
         rd_udf_q <= rd_udf_d;
      end
   end

   assign wr_overflow_o  = wr_ovf_q;
   assign rd_underflow_o = rd_udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (depth 8, width 32) with hand-computed expectations.
// Define SYNC_FIFO_ERR_FLAGS_EN to also check the error pulse outputs.
module tb_sync_fifo;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wr_en_i;
   logic [31:0] wr_data_i;
   logic        rd_en_i;
   logic        rd_data_valid_o;
   logic [31:0] rd_data_o;
   logic [3:0]  elem_cnt_o;
   logic        full_o;
   logic        empty_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic        wr_overflow_o;
   logic        rd_underflow_o;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   sync_fifo #(
      .DATA_WIDTH (32),
      .DATA_DEPTH (8)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .wr_en_i         (wr_en_i),
      .wr_data_i       (wr_data_i),
      .rd_en_i         (rd_en_i),
      .rd_data_valid_o (rd_data_valid_o),
      .rd_data_o       (rd_data_o),
      .elem_cnt_o      (elem_cnt_o),
      .full_o          (full_o),
      .empty_o         (empty_o)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      ,
      .wr_overflow_o   (wr_overflow_o),
      .rd_underflow_o  (rd_underflow_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one request set, let one rising edge sample it, then settle 1 ns.
   task automatic cyc(input logic wr, input logic [31:0] data, input logic rd);
      wr_en_i   = wr;
      wr_data_i = data;
      rd_en_i   = rd;
      @(posedge clk_i);
      #1;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
   endtask

   task automatic chk_status(input string tag, input int cnt, input logic full, input logic empty);
      chk({tag, "_cnt"},   32'(elem_cnt_o), 32'(cnt));
      chk({tag, "_full"},  32'(full_o),     32'(full));
      chk({tag, "_empty"}, 32'(empty_o),    32'(empty));
   endtask

   task automatic chk_rd(input string tag, input logic valid, input logic [31:0] data);
      chk({tag, "_valid"}, 32'(rd_data_valid_o), 32'(valid));
      chk({tag, "_data"},  rd_data_o,            data);
   endtask

   task automatic chk_reset(input string tag);
      chk_rd(tag, 1'b0, 32'd0);
      chk_status(tag, 0, 1'b0, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk({tag, "_ovf"}, 32'(wr_overflow_o),  32'd0);
      chk({tag, "_udf"}, 32'(rd_underflow_o), 32'd0);
`endif
   endtask

   int exp_cnt;

   initial begin
      rst_i     = 1'b1;
      wr_en_i   = 1'b0;
      wr_data_i = '0;
      rd_en_i   = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk_reset("reset");
      rst_i = 1'b0;

      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 32'd0, 1'b1);
         chk_rd("empty_rd", 1'b0, 32'd0);
         chk_status("empty_rd", 0, 1'b0, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         chk("empty_rd_udf", 32'(rd_underflow_o), 32'd1);
`endif
      end

      // 5..12 fill the FIFO; 13 and 14 are dropped.
      for (int v = 5; v <= 14; v++) begin
         cyc(1'b1, 32'(v), 1'b0);
         exp_cnt = (v <= 12) ? v - 4 : 8;
         chk_status("push", exp_cnt, exp_cnt == 8, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         chk("push_ovf", 32'(wr_overflow_o), 32'(v >= 13));
`endif
      end

      for (int v = 5; v <= 7; v++) begin
         cyc(1'b0, 32'd0, 1'b1);
         chk_rd("pop3", 1'b1, 32'(v));
         chk_status("pop3", 12 - v, 1'b0, 1'b0);
      end

      cyc(1'b1, 32'd23, 1'b1);
      chk_rd("rw23", 1'b1, 32'd8);
      chk_status("rw23", 5, 1'b0, 1'b0);
      cyc(1'b1, 32'd45, 1'b1);
      chk_rd("rw45", 1'b1, 32'd9);
      chk_status("rw45", 5, 1'b0, 1'b0);

      begin
         logic [31:0] drain [5] = '{32'd10, 32'd11, 32'd12, 32'd23, 32'd45};
         for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'd0, 1'b1);
            chk_rd("drain", 1'b1, drain[i]);
            chk_status("drain", 4 - i, 1'b0, i == 4);
         end
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 32'd0, 1'b1);
         chk_rd("drain_empty", 1'b0, 32'd45);
         chk_status("drain_empty", 0, 1'b0, 1'b1);
      end

      // Read on empty with a same-cycle write: read rejected, data appears next cycle.
      cyc(1'b1, 32'd77, 1'b1);
      chk_rd("no_fallthru", 1'b0, 32'd45);
      chk_status("no_fallthru", 1, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 1'b1);
      chk_rd("after_fallthru", 1'b1, 32'd77);
      chk_status("after_fallthru", 0, 1'b0, 1'b1);

      for (int v = 100; v < 108; v++) begin
         cyc(1'b1, 32'(v), 1'b0);
      end
      chk_status("refill", 8, 1'b1, 1'b0);

      cyc(1'b1, 32'd99, 1'b1);
      chk_rd("full_rw", 1'b1, 32'd100);
      chk_status("full_rw", 8, 1'b1, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("full_rw_ovf", 32'(wr_overflow_o), 32'd0);
`endif

      for (int v = 101; v < 108; v++) begin
         cyc(1'b0, 32'd0, 1'b1);
         chk_rd("drain_full", 1'b1, 32'(v));
      end
      cyc(1'b0, 32'd0, 1'b1);
      chk_rd("pass_thru_99", 1'b1, 32'd99);
      chk_status("pass_thru_99", 0, 1'b0, 1'b1);

      for (int v = 200; v < 203; v++) begin
         cyc(1'b1, 32'(v), 1'b0);
      end
      cyc(1'b0, 32'd0, 1'b1);
      chk_rd("pre_rst", 1'b1, 32'd200);
      chk_status("pre_rst", 2, 1'b0, 1'b0);

      // Assert reset between clock edges: outputs must clear without an edge.
      #2;
      rst_i = 1'b1;
      #1;
      chk_reset("async_rst");
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      #1;
      chk_reset("post_rst");

      cyc(1'b1, 32'd55, 1'b0);
      cyc(1'b0, 32'd0, 1'b1);
      chk_rd("post_rst_rd", 1'b1, 32'd55);
      chk_status("post_rst_rd", 0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got %0d checks expected completion", n_chk);
      $fatal(1, "timeout");
   end

endmodule
